// File: rtl/assert_arb_pkg.sv
// Shared defaults, report record and saturating-increment helper for the
// assertion-event arbiter.
package assert_arb_pkg;

    localparam int NUM_CH_DEFAULT = 3;
    localparam int CNT_W_DEFAULT  = 16;
    localparam int ID_W_MAX       = 3;

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic                pass;
    } evt_report_t;

    // Counters are carried in a 32-bit container, so widths above 32 are unsupported.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (cnt >= max_val) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: grants the first requester at or after
// ptr, wrapping modulo NUM_CH.
module rr_pick #(
    parameter int NUM_CH = 3,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [ID_W-1:0]   gnt_id
);

    logic          found;
    logic [ID_W:0] sum;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        sum    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // ptr and i are both below NUM_CH, so a single subtraction wraps the sum.
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_CH)) begin
                sum = sum - (ID_W+1)'(NUM_CH);
            end
            if (!found && req[sum[ID_W-1:0]]) begin
                gnt[sum[ID_W-1:0]] = 1'b1;
                gnt_id             = sum[ID_W-1:0];
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/assert_evt_arbiter.sv
// Round-robin arbiter that funnels per-checker pass/fail events into one
// registered report stream and keeps saturating per-channel statistics.
module assert_evt_arbiter
    import assert_arb_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       chk_valid,
    input  logic [NUM_CH-1:0]       chk_pass,
    output logic [NUM_CH-1:0]       chk_ready,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [ID_W-1:0]         evt_id,
    output logic                    evt_pass,
    output logic [NUM_CH*CNT_W-1:0] pass_cnt,
    output logic [NUM_CH*CNT_W-1:0] fail_cnt,
    input  logic                    clr_cnt,
    output logic                    any_fail
);

    logic              open;
    logic [NUM_CH-1:0] gnt;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W-1:0]   ptr;
    logic              accept;
    logic              acc_pass;
    logic              evt_valid_q;
    logic              any_fail_q;
    evt_report_t       rpt_q;

    assign open = !evt_valid_q || evt_ready;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_pick (
        .req    (chk_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign chk_ready = open ? gnt : '0;
    assign accept    = |(chk_valid & chk_ready);
    assign acc_pass  = chk_pass[gnt_id];

    // Output register refills on accept (even while draining) and empties on a bare drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid_q <= 1'b0;
            rpt_q       <= '0;
            ptr         <= '0;
        end else if (accept) begin
            evt_valid_q <= 1'b1;
            rpt_q.id    <= ID_W_MAX'(gnt_id);
            rpt_q.pass  <= acc_pass;
            ptr         <= (gnt_id == ID_W'(NUM_CH-1)) ? '0 : gnt_id + 1'b1;
        end else if (evt_ready) begin
            evt_valid_q <= 1'b0;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = ID_W'(rpt_q.id);
    assign evt_pass  = rpt_q.pass;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
        logic [CNT_W-1:0] pass_q;
        logic [CNT_W-1:0] fail_q;
        logic [31:0]      pass_nxt;
        logic [31:0]      fail_nxt;
        logic             hit;

        assign hit      = chk_valid[i] && chk_ready[i];
        assign pass_nxt = sat_inc(32'(pass_q), CNT_W);
        assign fail_nxt = sat_inc(32'(fail_q), CNT_W);

        // A clear wins over a same-cycle increment; the event itself is still reported.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pass_q <= '0;
                fail_q <= '0;
            end else if (clr_cnt) begin
                pass_q <= '0;
                fail_q <= '0;
            end else if (hit) begin
                if (chk_pass[i]) begin
                    pass_q <= CNT_W'(pass_nxt);
                end else begin
                    fail_q <= CNT_W'(fail_nxt);
                end
            end
        end

        assign pass_cnt[i*CNT_W +: CNT_W] = pass_q;
        assign fail_cnt[i*CNT_W +: CNT_W] = fail_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_fail_q <= 1'b0;
        end else if (clr_cnt) begin
            any_fail_q <= 1'b0;
        end else if (accept && !acc_pass) begin
            any_fail_q <= 1'b1;
        end
    end

    assign any_fail = any_fail_q;

endmodule

// File: tb/tb_assert_evt_arbiter.sv
// Directed scoreboard bench for assert_evt_arbiter with NUM_CH=3 and 2-bit
// counters so saturation is reachable in a few events.
module tb_assert_evt_arbiter;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 2;
    localparam int ID_W   = 2;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_CH-1:0]       chk_valid;
    logic [NUM_CH-1:0]       chk_pass;
    logic [NUM_CH-1:0]       chk_ready;
    logic                    evt_valid;
    logic                    evt_ready;
    logic [ID_W-1:0]         evt_id;
    logic                    evt_pass;
    logic [NUM_CH*CNT_W-1:0] pass_cnt;
    logic [NUM_CH*CNT_W-1:0] fail_cnt;
    logic                    clr_cnt;
    logic                    any_fail;

    typedef struct {
        logic [ID_W-1:0] id;
        logic            pass;
    } exp_evt_t;

    exp_evt_t exp_q[$];
    int       checks = 0;
    int       errors = 0;

    assert_evt_arbiter #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .ID_W   (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .chk_valid (chk_valid),
        .chk_pass  (chk_pass),
        .chk_ready (chk_ready),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_pass  (evt_pass),
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt),
        .clr_cnt   (clr_cnt),
        .any_fail  (any_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle: checks the combinational grant, scores the report port,
    // records any expected accept, then advances to just after the next edge.
    task automatic applyStimulus(input string tag, input logic [2:0] valid, input logic [2:0] pass,
                                 input logic ready, input logic clr, input logic [2:0] exp_ready);
        exp_evt_t e;
        chk_valid = valid;
        chk_pass  = pass;
        evt_ready = ready;
        clr_cnt   = clr;
        #3;
        checkOutput({tag, ".chk_ready"}, 32'(chk_ready), 32'(exp_ready));
        checkOutput({tag, ".evt_valid"}, 32'(evt_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            checkOutput({tag, ".evt_id"}, 32'(evt_id), 32'(exp_q[0].id));
            checkOutput({tag, ".evt_pass"}, 32'(evt_pass), 32'(exp_q[0].pass));
            if (ready) void'(exp_q.pop_front());
        end
        if ((valid & exp_ready) != 3'b000) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (exp_ready[i]) begin
                    e.id   = ID_W'(i);
                    e.pass = pass[i];
                end
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n     = 1'b0;
        chk_valid = '0;
        chk_pass  = '0;
        evt_ready = 1'b0;
        clr_cnt   = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        chk_valid = '0;
        chk_pass  = '0;
        evt_ready = 1'b0;
        clr_cnt   = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst.evt_valid", 32'(evt_valid), 32'd0);
        checkOutput("rst.evt_id", 32'(evt_id), 32'd0);
        checkOutput("rst.evt_pass", 32'(evt_pass), 32'd0);
        checkOutput("rst.pass_cnt", 32'(pass_cnt), 32'd0);
        checkOutput("rst.fail_cnt", 32'(fail_cnt), 32'd0);
        checkOutput("rst.any_fail", 32'(any_fail), 32'd0);
        rst_n = 1'b1;

        // Single ch1 pass event, then a full request set proves ptr moved to 2.
        applyStimulus("t1a", 3'b010, 3'b010, 1'b1, 1'b0, 3'b010);
        checkOutput("t1.evt_valid_lat", 32'(evt_valid), 32'd1);
        checkOutput("t1.pass_cnt1", 32'(pass_cnt[1*CNT_W +: CNT_W]), 32'd1);
        applyStimulus("t1b", 3'b111, 3'b111, 1'b1, 1'b0, 3'b100);
        applyStimulus("t1c", 3'b000, 3'b000, 1'b1, 1'b0, 3'b000);

        // Continuous requests from reset rotate 0,1,2 at one event per cycle.
        applyReset();
        applyStimulus("t2a", 3'b111, 3'b111, 1'b1, 1'b0, 3'b001);
        applyStimulus("t2b", 3'b111, 3'b111, 1'b1, 1'b0, 3'b010);
        applyStimulus("t2c", 3'b111, 3'b111, 1'b1, 1'b0, 3'b100);
        applyStimulus("t2d", 3'b111, 3'b111, 1'b1, 1'b0, 3'b001);
        applyStimulus("t2e", 3'b111, 3'b111, 1'b1, 1'b0, 3'b010);
        applyStimulus("t2f", 3'b111, 3'b111, 1'b1, 1'b0, 3'b100);
        applyStimulus("t2g", 3'b000, 3'b000, 1'b1, 1'b0, 3'b000);
        checkOutput("t2.pass_cnt", 32'(pass_cnt), 32'b10_10_10);

        // Backpressure: ch0 report held four cycles while ch2 waits ungranted.
        applyStimulus("t3a", 3'b001, 3'b001, 1'b1, 1'b0, 3'b001);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("t3stall", 3'b100, 3'b000, 1'b0, 1'b0, 3'b000);
        end
        applyStimulus("t3rel", 3'b100, 3'b000, 1'b1, 1'b0, 3'b100);
        applyStimulus("t3d", 3'b000, 3'b000, 1'b1, 1'b0, 3'b000);
        checkOutput("t4.fail_cnt2", 32'(fail_cnt[2*CNT_W +: CNT_W]), 32'd1);
        checkOutput("t4.any_fail_set", 32'(any_fail), 32'd1);

        // A later pass leaves the sticky flag alone; clear wipes everything.
        applyStimulus("t4a", 3'b100, 3'b100, 1'b1, 1'b0, 3'b100);
        applyStimulus("t4b", 3'b000, 3'b000, 1'b1, 1'b0, 3'b000);
        checkOutput("t4.any_fail_sticky", 32'(any_fail), 32'd1);
        checkOutput("t4.pass_cnt2", 32'(pass_cnt[2*CNT_W +: CNT_W]), 32'd3);
        applyStimulus("t4clr", 3'b000, 3'b000, 1'b1, 1'b1, 3'b000);
        checkOutput("t4.clr_pass", 32'(pass_cnt), 32'd0);
        checkOutput("t4.clr_fail", 32'(fail_cnt), 32'd0);
        checkOutput("t4.clr_any_fail", 32'(any_fail), 32'd0);

        // Five ch0 passes saturate a 2-bit counter at 3.
        for (int i = 0; i < 5; i++) begin
            applyStimulus("t5sat", 3'b001, 3'b001, 1'b1, 1'b0, 3'b001);
        end
        checkOutput("t5.pass_cnt0_sat", 32'(pass_cnt[0 +: CNT_W]), 32'd3);
        applyStimulus("t5clr", 3'b001, 3'b001, 1'b1, 1'b1, 3'b001);
        checkOutput("t5.clr_vs_inc", 32'(pass_cnt[0 +: CNT_W]), 32'd0);
        applyStimulus("t5e", 3'b000, 3'b000, 1'b1, 1'b0, 3'b000);
        checkOutput("t5.pass_cnt0_after", 32'(pass_cnt[0 +: CNT_W]), 32'd0);

        // Async reset while a report is stalled drops it without a clock edge.
        applyStimulus("t6a", 3'b010, 3'b010, 1'b1, 1'b0, 3'b010);
        applyStimulus("t6stall", 3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6.async_valid", 32'(evt_valid), 32'd0);
        checkOutput("t6.async_id", 32'(evt_id), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus("t6b", 3'b111, 3'b111, 1'b1, 1'b0, 3'b001);
        applyStimulus("t6c", 3'b000, 3'b000, 1'b1, 1'b0, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
